mor1kx_shadow_stack_checker: RTL and testbench

- Consumer of the register-file write-port snoop taps.
- Captures the link-register value written on each committed call and pushes it onto an internal hardware shadow stack.
- On each committed return, pops the stack and compares the popped value against the actual return target.
- Flags control-flow violations to the CSAW monitor logic. Sits beside the mor1kx register file in csaw_core.

---
 rtl/mor1kx_shadow_stack_checker.sv | 174 +++++++++++++++++
 tb/tb_mor1kx_shadow_stack_checker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_shadow_stack_checker.sv
// Hardware shadow stack: pushes link-register writes of committed calls and checks committed return targets.
// Optional MOR1KX_SHADOW_STACK_HALT_EN adds halt_o, which freezes the stack after a violation until clr_i.
module mor1kx_shadow_stack_checker #(
  parameter int          STACK_AW    = 4,
  parameter int          DATA_WIDTH  = 32,
  parameter logic [4:0]  LR_ADDR     = 5'd9,
  parameter int          ARM_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rf_we_i,
  input  logic [4:0]            rf_waddr_i,
  input  logic [DATA_WIDTH-1:0] rf_din_i,
  input  logic                  call_i,
  input  logic                  ret_i,
  input  logic [DATA_WIDTH-1:0] ret_target_i,
  input  logic                  clr_i,
  output logic                  violation_o,
  output logic [DATA_WIDTH-1:0] viol_expected_o,
  output logic [DATA_WIDTH-1:0] viol_actual_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  proto_err_o,
  output logic [STACK_AW:0]     depth_o,
`ifdef MOR1KX_SHADOW_STACK_HALT_EN
  output logic                  halt_o,
`endif
  output logic                  dbg_state_o
);

  localparam int DEPTH = 1 << STACK_AW;
  localparam int TW    = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(ARM_TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t                r_state;
  logic [TW-1:0]         r_tmo;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [STACK_AW-1:0]   r_sp;
  logic [STACK_AW:0]     r_count;
  logic                  r_rd_vld;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_rd_tgt;
  logic                  r_violation;
  logic [DATA_WIDTH-1:0] r_viol_exp;
  logic [DATA_WIDTH-1:0] r_viol_act;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_proto;
  logic                  r_halt;

  logic                  w_lr_wr;
  logic                  w_halt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_underflow;
  logic                  w_tmo_hit;
  logic                  w_proto;
  logic                  w_mismatch;
  logic                  w_full;
  logic [STACK_AW-1:0]   w_sp_dec;

`ifdef MOR1KX_SHADOW_STACK_HALT_EN
  assign w_halt = r_halt;
  assign halt_o = r_halt;
`else
  assign w_halt = 1'b0;
`endif

  // A committed ret always wins over a pending or same-cycle call, so push and pop never coincide.
  assign w_lr_wr     = rf_we_i && (rf_waddr_i == LR_ADDR);
  assign w_push      = !w_halt && !ret_i && w_lr_wr &&
                       ((r_state == S_IDLE && call_i) || r_state == S_ARMED);
  assign w_pop       = !w_halt && ret_i && (r_count != '0);
  assign w_underflow = !w_halt && ret_i && (r_count == '0);
  assign w_tmo_hit   = (r_state == S_ARMED) && !ret_i && !w_lr_wr && !call_i && (r_tmo == TMO_LAST);
  assign w_proto     = (call_i && ret_i) || (r_state == S_ARMED && ret_i) || w_tmo_hit;
  assign w_mismatch  = r_rd_vld && (r_rd_data != r_rd_tgt);
  assign w_full      = r_count[STACK_AW];
  assign w_sp_dec    = r_sp - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (call_i && !ret_i && !w_lr_wr) begin
            r_state <= S_ARMED;
            r_tmo   <= '0;
          end
        end
        S_ARMED: begin
          if (ret_i || w_lr_wr || w_tmo_hit) r_state <= S_IDLE;
          else if (call_i)                   r_tmo   <= '0;
          else                               r_tmo   <= r_tmo + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stack storage and read stage are not reset; r_rd_vld qualifies them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_sp] <= rf_din_i;
    if (w_pop) begin
      r_rd_data <= r_mem[w_sp_dec];
      r_rd_tgt  <= ret_target_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp     <= '0;
      r_count  <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_pop;
      if (w_push) begin
        r_sp <= r_sp + 1'b1;
        if (!w_full) r_count <= r_count + 1'b1;
      end else if (w_pop) begin
        r_sp    <= w_sp_dec;
        r_count <= r_count - 1'b1;
      end
    end
  end

  // New events are applied after the clear so a coinciding event survives clr_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_violation <= 1'b0;
      r_viol_exp  <= '0;
      r_viol_act  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_proto     <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      if (clr_i) begin
        r_violation <= 1'b0;
        r_viol_exp  <= '0;
        r_viol_act  <= '0;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        r_proto     <= 1'b0;
        r_halt      <= 1'b0;
      end
      if (w_mismatch) begin
        r_violation <= 1'b1;
        r_halt      <= 1'b1;
        if (!r_violation || clr_i) begin
          r_viol_exp <= r_rd_data;
          r_viol_act <= r_rd_tgt;
        end
      end
      if (w_push && w_full) r_overflow  <= 1'b1;
      if (w_underflow)      r_underflow <= 1'b1;
      if (w_proto)          r_proto     <= 1'b1;
    end
  end

  assign violation_o     = r_violation;
  assign viol_expected_o = r_viol_exp;
  assign viol_actual_o   = r_viol_act;
  assign overflow_o      = r_overflow;
  assign underflow_o     = r_underflow;
  assign proto_err_o     = r_proto;
  assign depth_o         = r_count;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_mor1kx_shadow_stack_checker.sv
// Directed bench for mor1kx_shadow_stack_checker: default instance plus a STACK_AW=2 instance on shared inputs.
module tb_mor1kx_shadow_stack_checker;

  logic        clk;
  logic        rst_n;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_din_i;
  logic        call_i;
  logic        ret_i;
  logic [31:0] ret_target_i;
  logic        clr_i;

  logic        violation_o, overflow_o, underflow_o, proto_err_o, dbg_state_o;
  logic [31:0] viol_expected_o, viol_actual_o;
  logic [4:0]  depth_o;
  logic        s_violation, s_overflow, s_underflow, s_proto, s_dbg_state;
  logic [31:0] s_viol_exp, s_viol_act;
  logic [2:0]  s_depth;
`ifdef MOR1KX_SHADOW_STACK_HALT_EN
  logic        halt_o, s_halt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mor1kx_shadow_stack_checker u_dut (
    .clk(clk), .rst_n(rst_n), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_din_i(rf_din_i),
    .call_i(call_i), .ret_i(ret_i), .ret_target_i(ret_target_i), .clr_i(clr_i),
    .violation_o(violation_o), .viol_expected_o(viol_expected_o), .viol_actual_o(viol_actual_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .proto_err_o(proto_err_o), .depth_o(depth_o),
`ifdef MOR1KX_SHADOW_STACK_HALT_EN
    .halt_o(halt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  mor1kx_shadow_stack_checker #(.STACK_AW(2)) u_small (
    .clk(clk), .rst_n(rst_n), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_din_i(rf_din_i),
    .call_i(call_i), .ret_i(ret_i), .ret_target_i(ret_target_i), .clr_i(clr_i),
    .violation_o(s_violation), .viol_expected_o(s_viol_exp), .viol_actual_o(s_viol_act),
    .overflow_o(s_overflow), .underflow_o(s_underflow), .proto_err_o(s_proto), .depth_o(s_depth),
`ifdef MOR1KX_SHADOW_STACK_HALT_EN
    .halt_o(s_halt),
`endif
    .dbg_state_o(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks: inputs change #1 after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] v);
    call_i = 1'b1; rf_we_i = 1'b1; rf_waddr_i = 5'd9; rf_din_i = v;
    tick();
    call_i = 1'b0; rf_we_i = 1'b0;
  endtask

  task automatic do_ret(input logic [31:0] t);
    ret_i = 1'b1; ret_target_i = t;
    tick();
    ret_i = 1'b0;
  endtask

  task automatic do_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rf_we_i = 1'b0; rf_waddr_i = '0; rf_din_i = '0;
    call_i = 1'b0; ret_i = 1'b0; ret_target_i = '0; clr_i = 1'b0;
    repeat (2) tick();
    check("rst_violation", 32'(violation_o), 32'd0);
    check("rst_exp",       viol_expected_o, 32'd0);
    check("rst_act",       viol_actual_o,   32'd0);
    check("rst_overflow",  32'(overflow_o),  32'd0);
    check("rst_underflow", 32'(underflow_o), 32'd0);
    check("rst_proto",     32'(proto_err_o), 32'd0);
    check("rst_depth",     32'(depth_o),     32'd0);
    rst_n = 1'b1;
    tick();

    // call, LR write two cycles later, matching return
    call_i = 1'b1;
    tick();
    call_i = 1'b0;
    check("t1_armed", 32'(dbg_state_o), 32'd1);
    tick();
    rf_we_i = 1'b1; rf_waddr_i = 5'd9; rf_din_i = 32'h0000_1000;
    tick();
    rf_we_i = 1'b0;
    check("t1_depth1", 32'(depth_o), 32'd1);
    check("t1_idle",   32'(dbg_state_o), 32'd0);
    do_ret(32'h0000_1000);
    check("t1_depth0", 32'(depth_o), 32'd0);
    tick(); tick();
    check("t1_noviol", 32'(violation_o), 32'd0);

    // three pushes, back-to-back returns; LIFO pops 0x300, 0x200, 0x100
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    check("t2_depth3", 32'(depth_o), 32'd3);
    do_ret(32'h300); do_ret(32'h200); do_ret(32'h204);
    check("t2_viol_1cyc", 32'(violation_o), 32'd0);
    tick();
    check("t2_viol_2cyc", 32'(violation_o), 32'd1);
    check("t2_exp",       viol_expected_o,  32'h100);
    check("t2_act",       viol_actual_o,    32'h204);
    check("t2_depth0",    32'(depth_o),     32'd0);
    do_clr();
    check("t2_clr_viol",  32'(violation_o), 32'd0);
    check("t2_clr_exp",   viol_expected_o,  32'd0);

    // small stack overflow and wrap-around
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    for (int i = 1; i <= 5; i++) do_push(32'(i * 16));
    check("t3_s_overflow", 32'(s_overflow), 32'd1);
    check("t3_s_depth4",   32'(s_depth),    32'd4);
    check("t3_overflow",   32'(overflow_o), 32'd0);
    check("t3_depth5",     32'(depth_o),    32'd5);
    do_ret(32'h50); do_ret(32'h40); do_ret(32'h30); do_ret(32'h20);
    tick(); tick();
    check("t3_s_noviol",   32'(s_violation), 32'd0);
    check("t3_s_depth0",   32'(s_depth),     32'd0);
    check("t3_s_no_uf",    32'(s_underflow), 32'd0);
    do_ret(32'h10);
    check("t3_s_underflow", 32'(s_underflow), 32'd1);
    check("t3_depth0",      32'(depth_o),     32'd0);
    tick(); tick();
    check("t3_noviol",      32'(violation_o), 32'd0);

    // arm timeout
    do_clr();
    do_push(32'hA0);
    check("t4_depth1", 32'(depth_o), 32'd1);
    call_i = 1'b1;
    tick();
    call_i = 1'b0;
    repeat (7) tick();
    check("t4_proto_early", 32'(proto_err_o), 32'd0);
    check("t4_still_armed", 32'(dbg_state_o), 32'd1);
    tick();
    check("t4_proto",       32'(proto_err_o), 32'd1);
    check("t4_idle",        32'(dbg_state_o), 32'd0);
    check("t4_depth_same",  32'(depth_o),     32'd1);
    rf_we_i = 1'b1; rf_waddr_i = 5'd9; rf_din_i = 32'hBEEF;
    tick();
    rf_we_i = 1'b0;
    check("t4_no_push",     32'(depth_o),     32'd1);

    // call and ret in the same cycle, then clear
    do_clr();
    check("t5_clr_proto", 32'(proto_err_o), 32'd0);
    call_i = 1'b1; ret_i = 1'b1; ret_target_i = 32'hA0;
    tick();
    call_i = 1'b0; ret_i = 1'b0;
    check("t5_proto",  32'(proto_err_o), 32'd1);
    check("t5_depth0", 32'(depth_o),     32'd0);
    check("t5_idle",   32'(dbg_state_o), 32'd0);
    tick(); tick();
    check("t5_noviol", 32'(violation_o), 32'd0);
    do_ret(32'h0);
    check("t5_underflow", 32'(underflow_o), 32'd1);
    do_clr();
    check("t5_clr_violation", 32'(violation_o), 32'd0);
    check("t5_clr_overflow",  32'(overflow_o),  32'd0);
    check("t5_clr_underflow", 32'(underflow_o), 32'd0);
    check("t5_clr_proto2",    32'(proto_err_o), 32'd0);

    // asynchronous reset mid-stream
    do_push(32'h1); do_push(32'h2); do_push(32'h3); do_push(32'h4);
    do_ret(32'h99);
    tick();
    check("t6_viol",  32'(violation_o), 32'd1);
    check("t6_exp",   viol_expected_o,  32'h4);
    check("t6_depth", 32'(depth_o),     32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_arst_violation", 32'(violation_o), 32'd0);
    check("t6_arst_exp",       viol_expected_o,  32'd0);
    check("t6_arst_act",       viol_actual_o,    32'd0);
    check("t6_arst_depth",     32'(depth_o),     32'd0);
    check("t6_arst_proto",     32'(proto_err_o), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    do_ret(32'h3);
    check("t6_underflow", 32'(underflow_o), 32'd1);
    check("t6_depth0",    32'(depth_o),     32'd0);
    tick(); tick();
    check("t6_noviol",    32'(violation_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
